control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Consumer end of the instruction-word decoder interface.
- Fetches and holds the instruction word and drives the decoder `state` input from the decoder's `next_state` field.
- Unpacks the 33-bit control word into individual datapath controls, gating all write enables outside execute.
- Holds the architectural status register; counts retired instructions; traps on a reserved next-state code.

Parameters:
- CW_WIDTH, 33, control word width; layout below is fixed for 33.
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- instr_in  input  32  instruction word from instruction memory
- instr_valid  input  1  instr_in valid this cycle
- fetch_req  output  1  sequencer requests an instruction
- I  output  32  latched instruction register, to decoders
- state  output  2  decoder state, to decoders
- cw_in  input  33  control word from the selected decoder
- status_in  input  5  ALU flags {V,C,N,Z,zero-detect} this cycle
- status  output  5  registered status, to decoders
- alu_en, alu_bs  output  1 each  from cw[32], cw[31]
- alu_fs  output  5  cw[30:26]
- rf_b_en  output  1  cw[25]
- rf_sa, rf_sb, rf_da  output  5 each  cw[24:20], cw[19:15], cw[14:10]
- rf_w  output  1  cw[9], gated
- ram_en  output  1  cw[8]
- ram_w  output  1  cw[7], gated
- pc_en  output  1  cw[6], gated
- pc_fs  output  2  cw[5:4]
- pc_is  output  1  cw[3]
- status_ld  output  1  cw[2], gated
- retire  output  1  one-cycle pulse on the last execute cycle
- instr_count  output  CNT_WIDTH  retired instructions
- fault  output  1  sticky trap flag

Behaviour:
- Phases: FETCH, EXEC, FAULT (2-bit encoded).
- Reset (synchronous, wins over everything):
  - Phase = FETCH; I = 0; state = 00; status = 0; instr_count = 0; fault = 0.
  - A reset in any phase, including mid-EXEC, abandons the instruction with no writes.
- FETCH:
  - fetch_req = 1.
  - On a cycle with instr_valid = 1: I <= instr_in, state <= 00, phase <= EXEC.
  - With instr_valid = 0: hold; wait is unbounded.
- EXEC:
  - fetch_req = 0.
  - Outputs are combinationally unpacked from cw_in; gated enables equal their cw bit.
  - Each cycle: state <= cw_in[1:0].
  - cw_in[1:0] = 00: last cycle. retire = 1, instr_count += 1 (wraps modulo 2^CNT_WIDTH), phase <= FETCH.
  - cw_in[1:0] = 01 or 10: remain in EXEC.
  - cw_in[1:0] = 11 (reserved): phase <= FAULT, fault <= 1. That cycle's gated enables are forced 0; no retire.
- Status register:
  - status <= status_in at the clock edge ending any EXEC cycle with cw_in[2] = 1 and no fault.
  - Otherwise status holds.
- Outside EXEC (FETCH, FAULT):
  - rf_w, ram_w, pc_en, status_ld = 0; retire = 0.
  - Ungated fields still reflect cw_in and are don't-care.
- FAULT: all gated enables 0, fetch_req = 0, fault = 1, I and state hold. Left only by reset.
- Latency:
  - Fetch to first execute: 1 cycle after instr_valid is sampled.
  - Multi-cycle instructions take exactly N EXEC cycles, where N is the number of decoder states visited.
- instr_valid during EXEC or FAULT is ignored.
- No combinational path from instr_in to any output; I is registered.

Test Plan:
- Reset then idle, instr_valid = 0 for 10 cycles:
  - fetch_req = 1, state = 00, all gated enables 0, instr_count = 0.
- Fetch 0xF2A24683 (MOVK X3, #0x1234, LSL 16); bench decoder model returns next_state 01 then 00, with rf_w = 1 both cycles and pc_fs = 00 then 01:
  - I = 0xF2A24683.
  - state sequence 00, 01.
  - rf_w high for exactly 2 cycles, rf_da = 3.
  - retire pulses on the 2nd EXEC cycle; instr_count = 1; fetch_req returns high the next cycle.
- Single-cycle ADDS-style cw (next_state 00, status_ld = 1), status_in = 5'b01010:
  - status = 5'b01010 after the edge.
  - A following cw with status_ld = 0 and status_in = 5'b11111 leaves status at 5'b01010.
- cw_in[1:0] = 11 in EXEC with rf_w = 1:
  - rf_w = 0 that cycle; fault = 1 from next cycle, sticky.
  - instr_count unchanged; fetch_req = 0 until reset.
- Reset asserted on the 1st EXEC cycle of a 2-cycle instruction:
  - Next cycle phase = FETCH, I = 0, state = 00, instr_count unchanged from 0; no retire.
- CNT_WIDTH = 4, retire 16 instructions:
  - instr_count wraps from 15 to 0; retire count = 16.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer
//   Consumer end of the instruction-word decoder interface. Latches the
//   instruction word, steps the decoder state from the control word's
//   next-state field, and unpacks the 33-bit control word into datapath
//   controls. Write-type enables are only live while an instruction executes.
//   Also holds the status register, counts retired instructions, and traps
//   (sticky until reset) on the reserved next-state code 2'b11.
//
// Ports
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   instr_in/instr_valid : instruction word handshake from instruction memory
//   fetch_req            : sequencer is waiting for an instruction
//   I, state             : instruction register and decoder state, to decoders
//   cw_in                : control word from the selected decoder
//   status_in / status   : ALU flags this cycle / registered flags to decoders
//   alu_*, rf_*, ram_*, pc_*, status_ld : unpacked control-word fields
//   retire, instr_count  : retire pulse and retired-instruction counter
//   fault                : sticky trap flag
module control_sequencer #(
    parameter int CW_WIDTH  = 33,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          instr_in,
    input  logic                 instr_valid,
    output logic                 fetch_req,
    output logic [31:0]          I,
    output logic [1:0]           state,
    input  logic [CW_WIDTH-1:0]  cw_in,
    input  logic [4:0]           status_in,
    output logic [4:0]           status,
    output logic                 alu_en,
    output logic                 alu_bs,
    output logic [4:0]           alu_fs,
    output logic                 rf_b_en,
    output logic [4:0]           rf_sa,
    output logic [4:0]           rf_sb,
    output logic [4:0]           rf_da,
    output logic                 rf_w,
    output logic                 ram_en,
    output logic                 ram_w,
    output logic                 pc_en,
    output logic [1:0]           pc_fs,
    output logic                 pc_is,
    output logic                 status_ld,
    output logic                 retire,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic                 fault
);

    typedef enum logic [1:0] {
        PH_FETCH = 2'd0,
        PH_EXEC  = 2'd1,
        PH_FAULT = 2'd2
    } phase_t;

    phase_t     phase, phase_nxt;
    logic [1:0] ns;
    logic       trap;
    logic       upd_status;

    assign ns = cw_in[1:0];

    // Ungated fields pass straight through; they are don't-care outside EXEC.
    assign alu_en  = cw_in[32];
    assign alu_bs  = cw_in[31];
    assign alu_fs  = cw_in[30:26];
    assign rf_b_en = cw_in[25];
    assign rf_sa   = cw_in[24:20];
    assign rf_sb   = cw_in[19:15];
    assign rf_da   = cw_in[14:10];
    assign ram_en  = cw_in[8];
    assign pc_fs   = cw_in[5:4];
    assign pc_is   = cw_in[3];

    always_comb begin
        phase_nxt  = phase;
        fetch_req  = 1'b0;
        retire     = 1'b0;
        trap       = 1'b0;
        upd_status = 1'b0;
        rf_w       = 1'b0;
        ram_w      = 1'b0;
        pc_en      = 1'b0;
        status_ld  = 1'b0;
        case (phase)
            PH_FETCH: begin
                fetch_req = 1'b1;
                if (instr_valid) phase_nxt = PH_EXEC;
            end
            PH_EXEC: begin
                if (ns == 2'b11) begin
                    // Reserved next-state: suppress every write this cycle.
                    trap      = 1'b1;
                    phase_nxt = PH_FAULT;
                end else begin
                    rf_w       = cw_in[9];
                    ram_w      = cw_in[7];
                    pc_en      = cw_in[6];
                    status_ld  = cw_in[2];
                    upd_status = cw_in[2];
                    if (ns == 2'b00) begin
                        retire    = 1'b1;
                        phase_nxt = PH_FETCH;
                    end
                end
            end
            default: phase_nxt = PH_FAULT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase       <= PH_FETCH;
            I           <= '0;
            state       <= 2'b00;
            status      <= '0;
            instr_count <= '0;
            fault       <= 1'b0;
        end else begin
            phase <= phase_nxt;
            if (phase == PH_FETCH && instr_valid) begin
                I     <= instr_in;
                state <= 2'b00;
            end
            if (phase == PH_EXEC) state <= ns;
            if (upd_status) status <= status_in;
            if (retire) instr_count <= instr_count + CNT_WIDTH'(1);
            if (trap) fault <= 1'b1;
        end
    end

endmodule
